// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-port arbitration bundle: requester-side command streams
// in, one-hot grant and the muxed RAM write stream out.
interface fb_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_start;
  logic [NUM_REQ-1:0]        grant;
  logic [ADDR_W-1:0]         fb_addr;
  logic [DATA_W-1:0]         fb_data;
  logic                      fb_we;
  logic                      fb_start;
  logic                      busy;
  logic                      timeout;

  // Requester / stimulus side
  modport master (
    output req, req_done, req_addr, req_data, req_we, req_start,
    input  grant, fb_addr, fb_data, fb_we, fb_start, busy, timeout
  );

  // Arbiter side
  modport slave (
    input  req, req_done, req_addr, req_data, req_we, req_start,
    output grant, fb_addr, fb_data, fb_we, fb_start, busy, timeout
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the single framebuffer write port. One engine owns
// the port at a time until it completes, drops its request, or the watchdog
// fires; a dead cycle separates owners. The muxed write stream is registered.
module fb_write_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  fb_write_arbiter_if.slave    bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0]  fb_data_q, fb_data_d;
  logic               fb_we_q, fb_we_d;
  logic               fb_start_q, fb_start_d;

  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_we;
  logic               sel_start;
  logic               sel_done;
  logic               sel_req;
  logic [IDX_W-1:0]   pick;
  logic               wd_expired;
  logic               release_now;

  // First set request searching upward from the requester after last owner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!found && r[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  // Mux the current owner's command signals; all others are ignored.
  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    sel_we    = 1'b0;
    sel_start = 1'b0;
    sel_done  = 1'b0;
    sel_req   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = bus.req_data[i*DATA_W +: DATA_W];
        sel_we    = bus.req_we[i];
        sel_start = bus.req_start[i];
        sel_done  = bus.req_done[i];
        sel_req   = bus.req[i];
      end else begin
        sel_addr  = sel_addr;
      end
    end
  end

  assign pick        = rr_pick(bus.req, last_q);
  assign wd_expired  = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign release_now = sel_done | ~sel_req | wd_expired;

  // Next-state and registered-output computation for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    wdog_d     = wdog_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    fb_we_d    = 1'b0;
    fb_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fb_addr_d = '0;
        fb_data_d = '0;
        if (|bus.req) begin
          gidx_d  = pick;
          grant_d = NUM_REQ'(1) << pick;
          busy_d  = 1'b1;
          wdog_d  = '0;
          state_d = ST_GRANT;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        fb_addr_d = sel_addr;
        fb_data_d = sel_data;
        wdog_d    = wdog_q + WD_W'(1);
        if (release_now) begin
          grant_d    = '0;
          busy_d     = 1'b0;
          last_d     = gidx_q;
          state_d    = ST_RELEASE;
          // Only a completing owner's final write reaches the RAM.
          fb_we_d    = sel_we & sel_done;
          fb_start_d = sel_start & sel_done;
          // Completion or withdrawal takes precedence over the watchdog.
          timeout_d  = wd_expired & ~sel_done & sel_req;
        end else begin
          fb_we_d    = sel_we;
          fb_start_d = sel_start;
        end
      end
      ST_RELEASE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      wdog_q     <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      wdog_q     <= wdog_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
      fb_start_q <= fb_start_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_start = fb_start_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter (4 requesters, 8-cycle watchdog).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_fb_write_arbiter;

  logic clk;
  logic reset;
  int   vec;
  int   miss;

  fb_write_arbiter_if #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(8)) bus ();

  fb_write_arbiter #(
    .NUM_REQ(4), .ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req       = 4'b0000;
    bus.req_done  = 4'b0000;
    bus.req_we    = 4'b0000;
    bus.req_start = 4'b0000;
    bus.req_addr  = 64'd0;
    bus.req_data  = 32'd0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vec++; if (bus.grant !== 4'b0000) begin miss++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
    vec++; if (bus.fb_addr !== 16'h0000 || bus.fb_data !== 8'h00) begin miss++; $display("FAIL reset_fb: got %h/%h expected 0000/00", bus.fb_addr, bus.fb_data); end
    vec++; if ({bus.fb_we, bus.fb_start, bus.busy, bus.timeout} !== 4'b0000) begin miss++; $display("FAIL reset_flags: got %b expected 0000", {bus.fb_we, bus.fb_start, bus.busy, bus.timeout}); end
  endtask

  task automatic test_single();
    bus.req = 4'b0001;
    bus.req_addr[15:0] = 16'h0123;
    bus.req_data[7:0]  = 8'h5A;
    bus.req_we[0]      = 1'b1;
    step(1);
    vec++; if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin miss++; $display("FAIL single_grant: got %b busy %b expected 0001 busy 1", bus.grant, bus.busy); end
    vec++; if (bus.fb_we !== 1'b0) begin miss++; $display("FAIL single_lag: got fb_we %b expected 0", bus.fb_we); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      vec++; if (bus.fb_we !== 1'b1 || bus.fb_addr !== 16'h0123 || bus.fb_data !== 8'h5A) begin miss++; $display("FAIL single_write%0d: got we %b %h/%h expected 1 0123/5a", i, bus.fb_we, bus.fb_addr, bus.fb_data); end
    end
    bus.req_we[0]   = 1'b0;
    bus.req_done[0] = 1'b1;
    step(1);
    vec++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.fb_we !== 1'b0) begin miss++; $display("FAIL single_release: got %b busy %b we %b expected 0000 0 0", bus.grant, bus.busy, bus.fb_we); end
    clear_inputs();
    step(1);
    vec++; if (bus.grant !== 4'b0000 || bus.timeout !== 1'b0) begin miss++; $display("FAIL single_release_cycle: got %b timeout %b expected 0000 0", bus.grant, bus.timeout); end
    step(1);
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [0:4];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    apply_reset();
    bus.req = 4'b1111;
    step(1);
    vec++; if (bus.grant !== exp_g[0]) begin miss++; $display("FAIL rot_first: got %b expected %b", bus.grant, exp_g[0]); end
    for (int k = 0; k < 4; k++) begin
      step(4);
      vec++; if (bus.grant !== exp_g[k]) begin miss++; $display("FAIL rot_hold%0d: got %b expected %b", k, bus.grant, exp_g[k]); end
      bus.req_done = exp_g[k];
      step(1);
      bus.req_done = 4'b0000;
      vec++; if (bus.grant !== 4'b0000) begin miss++; $display("FAIL rot_gap_a%0d: got %b expected 0000", k, bus.grant); end
      step(1);
      vec++; if (bus.grant !== 4'b0000) begin miss++; $display("FAIL rot_gap_b%0d: got %b expected 0000", k, bus.grant); end
      step(1);
      vec++; if (bus.grant !== exp_g[k+1]) begin miss++; $display("FAIL rot_next%0d: got %b expected %b", k, bus.grant, exp_g[k+1]); end
    end
    clear_inputs();
    step(3);
  endtask

  task automatic test_wrap();
    bus.req = 4'b0100;
    step(1);
    vec++; if (bus.grant !== 4'b0100) begin miss++; $display("FAIL wrap_serve2: got %b expected 0100", bus.grant); end
    bus.req_done = 4'b0100;
    step(1);
    bus.req_done = 4'b0000;
    bus.req      = 4'b0101;
    step(2);
    vec++; if (bus.grant !== 4'b0001) begin miss++; $display("FAIL wrap_to0: got %b expected 0001", bus.grant); end
    clear_inputs();
    step(3);
  endtask

  task automatic test_timeout();
    bus.req = 4'b1010;
    step(1);
    vec++; if (bus.grant !== 4'b0010) begin miss++; $display("FAIL to_grant1: got %b expected 0010", bus.grant); end
    for (int i = 0; i < 7; i++) begin
      step(1);
      vec++; if (bus.grant !== 4'b0010 || bus.timeout !== 1'b0) begin miss++; $display("FAIL to_hold%0d: got %b timeout %b expected 0010 0", i, bus.grant, bus.timeout); end
    end
    step(1);
    vec++; if (bus.grant !== 4'b0000 || bus.timeout !== 1'b1) begin miss++; $display("FAIL to_fire: got %b timeout %b expected 0000 1", bus.grant, bus.timeout); end
    step(1);
    vec++; if (bus.timeout !== 1'b0) begin miss++; $display("FAIL to_pulse: got timeout %b expected 0", bus.timeout); end
    step(1);
    vec++; if (bus.grant !== 4'b1000) begin miss++; $display("FAIL to_next3: got %b expected 1000", bus.grant); end
    clear_inputs();
    step(3);
  endtask

  task automatic test_done_at_expiry();
    bus.req = 4'b0001;
    step(1);
    vec++; if (bus.grant !== 4'b0001) begin miss++; $display("FAIL exp_grant: got %b expected 0001", bus.grant); end
    step(7);
    bus.req_done = 4'b0001;
    step(1);
    vec++; if (bus.grant !== 4'b0000 || bus.timeout !== 1'b0) begin miss++; $display("FAIL exp_done: got %b timeout %b expected 0000 0", bus.grant, bus.timeout); end
    clear_inputs();
    step(3);
  endtask

  task automatic test_nongranted();
    bus.req = 4'b0001;
    bus.req_addr[15:0] = 16'h1111;
    bus.req_data[7:0]  = 8'h11;
    bus.req_we[0]      = 1'b1;
    step(1);
    vec++; if (bus.grant !== 4'b0001) begin miss++; $display("FAIL ng_grant: got %b expected 0001", bus.grant); end
    bus.req_addr[47:32] = 16'hBEEF;
    bus.req_data[23:16] = 8'hEE;
    bus.req_we[2]       = 1'b1;
    bus.req_start[2]    = 1'b1;
    bus.req_done[2]     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      vec++; if (bus.grant !== 4'b0001 || bus.fb_addr !== 16'h1111 || bus.fb_data !== 8'h11 || bus.fb_we !== 1'b1 || bus.fb_start !== 1'b0) begin
        miss++; $display("FAIL ng_isolate%0d: got %b %h/%h we %b st %b expected 0001 1111/11 we 1 st 0", i, bus.grant, bus.fb_addr, bus.fb_data, bus.fb_we, bus.fb_start);
      end
    end
    clear_inputs();
    step(1);
    vec++; if (bus.grant !== 4'b0000 || bus.fb_we !== 1'b0) begin miss++; $display("FAIL ng_drop: got %b we %b expected 0000 0", bus.grant, bus.fb_we); end
    step(2);
  endtask

  task automatic test_final_write();
    bus.req = 4'b0001;
    step(1);
    vec++; if (bus.grant !== 4'b0001) begin miss++; $display("FAIL fw_grant: got %b expected 0001", bus.grant); end
    bus.req_addr[15:0] = 16'h0456;
    bus.req_data[7:0]  = 8'h77;
    bus.req_we[0]      = 1'b1;
    bus.req_done[0]    = 1'b1;
    step(1);
    vec++; if (bus.grant !== 4'b0000 || bus.fb_we !== 1'b1 || bus.fb_addr !== 16'h0456 || bus.fb_data !== 8'h77) begin
      miss++; $display("FAIL fw_forward: got %b we %b %h/%h expected 0000 1 0456/77", bus.grant, bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    clear_inputs();
    step(1);
    vec++; if (bus.fb_we !== 1'b0) begin miss++; $display("FAIL fw_cleared: got we %b expected 0", bus.fb_we); end
    step(2);
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0001;
    bus.req_addr[15:0] = 16'h0222;
    bus.req_we[0]      = 1'b1;
    step(3);
    vec++; if (bus.fb_we !== 1'b1 || bus.grant !== 4'b0001) begin miss++; $display("FAIL rm_active: got %b we %b expected 0001 1", bus.grant, bus.fb_we); end
    reset = 1'b1;
    step(1);
    vec++; if (bus.grant !== 4'b0000 || bus.fb_we !== 1'b0 || bus.fb_addr !== 16'h0000 || bus.busy !== 1'b0) begin
      miss++; $display("FAIL rm_cleared: got %b we %b addr %h busy %b expected 0000 0 0000 0", bus.grant, bus.fb_we, bus.fb_addr, bus.busy);
    end
    reset = 1'b0;
    clear_inputs();
    bus.req = 4'b0010;
    step(1);
    vec++; if (bus.grant !== 4'b0010) begin miss++; $display("FAIL rm_regrant: got %b expected 0010", bus.grant); end
    clear_inputs();
    step(3);
  endtask

  initial begin
    vec   = 0;
    miss  = 0;
    reset = 1'b1;
    clear_inputs();
    step(1);
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_done_at_expiry();
    test_nongranted();
    test_final_write();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Round-robin arbiter that shares the single framebuffer write port between NUM_REQ command engines (fill-rect, blank-panel, pixel-write, and others).
- Grants the port to one requester at a time.
- Holds the grant until that requester signals completion, withdraws its request, or a watchdog expires.
- Registers the muxed write stream toward the framebuffer RAM.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, width of the flattened framebuffer address.
- DATA_W, 8, width of the write data byte.
- TIMEOUT_CYCLES, 4096, maximum cycles a grant may be held before forced release (>=2).

Ports:
- clk  in  1  arbiter and write-port clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  level request per requester; held until done.
- req_done  in  NUM_REQ  one-cycle completion pulse per requester.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address, requester i at slice [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  per-requester write data.
- req_we  in  NUM_REQ  per-requester write enable.
- req_start  in  NUM_REQ  per-requester ram_access_start.
- grant  out  NUM_REQ  one-hot grant (registered).
- fb_addr  out  ADDR_W  muxed address to RAM (registered).
- fb_data  out  DATA_W  muxed data (registered).
- fb_we  out  1  muxed write enable (registered).
- fb_start  out  1  muxed access start (registered).
- busy  out  1  high while any grant is active.
- timeout  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset: grant=0, fb_addr=0, fb_data=0, fb_we=0, fb_start=0, busy=0, timeout=0.
- Reset internals: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), watchdog=0.
- Reset asserted mid-grant drops the grant and all outputs on the next edge; no partial write continues.

FSM:
- IDLE:
  - If any req bit is set, select the first set bit searching (last_grant+1) mod NUM_REQ upward with wrap.
  - Next cycle: grant gets that one-hot, busy=1, watchdog=0, go to GRANT.
  - If no req: remain in IDLE, outputs hold zero.
- GRANT (index g):
  - Each cycle fb_addr/fb_data/fb_we/fb_start are registered from requester g's slices, giving 1-cycle latency from requester to RAM.
  - Watchdog increments each cycle.
  - Release conditions, any of:
    - req_done[g]=1.
    - req[g]=0.
    - watchdog == TIMEOUT_CYCLES-1.
  - On release: grant=0, busy=0, fb_we=0, fb_start=0, last_grant=g, go to RELEASE.
  - timeout=1 for that cycle only if the watchdog was the sole release cause.
  - If req_done[g] coincides with watchdog expiry, it is treated as a normal completion and no timeout pulse is issued.
  - Write on the release cycle: the requester's final req_we in the same cycle as req_done is still forwarded.
    - fb_we is high on the following edge.
    - fb_we and fb_start are forced to 0 one cycle after that.
- RELEASE:
  - One mandatory idle cycle: fb_we=fb_start=0, timeout cleared, go to IDLE.
  - Guarantees a dead cycle between owners so RAM-side handshakes settle.

Non-granted requesters:
- req_we, req_start and req_done from non-granted requesters are ignored and have no side effects.
- A request arriving during GRANT or RELEASE waits and is evaluated in the next IDLE.

Fairness and latency:
- Arbitration latency: req rising in IDLE gives grant on the next edge.
- Minimum turnaround between two grants is 2 cycles (release edge, then RELEASE, then IDLE grant).
- With all requesters continuously asserting, grants rotate 0,1,2,3,0,...
- A single continuous requester is re-granted after each release.

Output invariants:
- grant is always one-hot or zero.
- fb_we never asserts while grant=0, except the single forwarded final write.

Test Plan:
- Reset then req=4'b0001; requester 0 drives addr=0x0123, data=0x5A, we=1 for 3 cycles, then done → grant=0001 one cycle after req; fb_addr=0x0123, fb_data=0x5A, fb_we=1 for 3 cycles (1-cycle lag); grant=0 after done, busy falls, one RELEASE cycle.
- req=4'b1111 held; each owner pulses done after 5 cycles → grant sequence 0001,0010,0100,1000,0001, with exactly 2 idle cycles between grants.
- After requester 2 served, req=4'b0101 → requester 0 granted next (wrap from last_grant=2 goes to 3, then 0).
- TIMEOUT_CYCLES=8, requester 1 never pulses done → grant released on the 8th GRANT cycle; timeout pulses exactly once; requester 3 (pending) is granted 2 cycles later.
- req_done[g] in the same cycle as watchdog expiry → release occurs, timeout stays 0.
- Non-granted requester 2 drives we=1 and done pulses while requester 0 owns the port → fb_* reflect only requester 0; grant unchanged.
- Reset asserted in the 3rd GRANT cycle → all outputs 0 next edge; after reset release with req=0010, requester 1 is granted (last_grant reset to NUM_REQ-1, search starts at 0 and finds 1).
